decodificador_varredura: RTL and testbench

- Parametrised, time-multiplexed BCD-to-7-segment display driver for the frequency meter.
- Replaces per-digit combinational decoders with one shared segment bus plus one-hot digit enables.
- Adds a load snapshot, leading-zero blanking, invalid-digit marking, a range (seletor) slot with decimal point, and anti-ghosting blanking.
- Sits between the BCD counter/latch stage and the board display pins.

---
 rtl/decodificador_varredura_if.sv | 35 +++
 rtl/decodificador_varredura.sv | 130 +++++++++++++
 tb/tb_decodificador_varredura.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/decodificador_varredura_if.sv
// Display bus between the BCD latch stage and the scanned 7-segment driver.
//
// Signals:
//   limpar    - blank the display while scanning continues.
//   carregar  - snapshot strobe. valor and seletor are captured on every rising
//               clk where carregar=1. There is no back-pressure: the strobe is
//               always accepted, and valor/seletor are ignored while it is low.
//   valor     - 4*N_DIGITOS BCD digits, nibble 0 is least significant.
//   seletor   - range code 0..7, shown in the extra slot with the decimal point.
//   segmentos - g,f,e,d,c,b,a (bit 6..0).
//   ponto     - decimal point drive.
//   anodo     - one-hot digit enable, bit N_DIGITOS is the seletor slot.
//
// Modports: master drives the inputs and reads the display drive; slave is the driver.
interface decodificador_varredura_if #(
  parameter int N_DIGITOS = 5
);
  logic                   limpar;
  logic                   carregar;
  logic [4*N_DIGITOS-1:0] valor;
  logic [2:0]             seletor;
  logic [6:0]             segmentos;
  logic                   ponto;
  logic [N_DIGITOS:0]     anodo;

  modport master (
    output limpar, carregar, valor, seletor,
    input  segmentos, ponto, anodo
  );

  modport slave (
    input  limpar, carregar, valor, seletor,
    output segmentos, ponto, anodo
  );
endinterface

// File: rtl/decodificador_varredura.sv
// Time-multiplexed BCD-to-7-segment driver for the frequency meter.
// One shared segment bus is scanned across N_DIGITOS value digits plus one
// range (seletor) slot, with one-hot digit enables.
//
// Ports:
//   clk   - system clock, all state changes on the rising edge.
//   reset - synchronous, active-high; has priority over every other input.
//   bus   - decodificador_varredura_if.slave (limpar, carregar, valor, seletor
//           in; segmentos, ponto, anodo out, all registered).
//
// Parameters:
//   N_DIGITOS     - number of BCD value digits (>=1).
//   DIV_VARREDURA - clock cycles per scan slot (>=2).
//   ATIVO_BAIXO   - 1: outputs active-low, 0: active-high.
module decodificador_varredura #(
  parameter int N_DIGITOS     = 5,
  parameter int DIV_VARREDURA = 1000,
  parameter int ATIVO_BAIXO   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  decodificador_varredura_if.slave  bus
);
  localparam int IW = (N_DIGITOS >= 1) ? $clog2(N_DIGITOS + 1) : 1;
  localparam int CW = $clog2(DIV_VARREDURA);

  localparam logic [CW-1:0]      CNT_LAST  = CW'(DIV_VARREDURA - 1);
  localparam logic [IW-1:0]      IDX_LAST  = IW'(N_DIGITOS);
  localparam logic               INV       = (ATIVO_BAIXO != 0);
  localparam logic [N_DIGITOS:0] ANODO_UM  = {{N_DIGITOS{1'b0}}, 1'b1};

  // Inactive levels for the current polarity.
  localparam logic [6:0]         SEG_OFF   = {7{INV}};
  localparam logic [N_DIGITOS:0] ANODO_OFF = {(N_DIGITOS + 1){INV}};

  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic [4*N_DIGITOS-1:0] snap_valor;
  logic [2:0]             snap_sel;

  logic [3:0]             digito;
  logic                   resto_nz;
  logic [6:0]             seg_act;
  logic                   ponto_act;
  logic [N_DIGITOS:0]     anodo_act;

  // Active-high segment pattern, bit 6..0 = g..a. 10..15 show '-'.
  function automatic logic [6:0] bcd_para_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  // Digit for the current slot, and whether this or any more significant
  // nibble is nonzero (drives leading-zero blanking).
  always_comb begin
    digito   = 4'd0;
    resto_nz = 1'b0;
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (idx == IW'(i)) begin
        digito = snap_valor[4*i +: 4];
      end
      if ((IW'(i) >= idx) && (snap_valor[4*i +: 4] != 4'd0)) begin
        resto_nz = 1'b1;
      end
    end
  end

  always_comb begin
    seg_act   = bcd_para_seg(digito);
    ponto_act = 1'b0;
    if (idx == IDX_LAST) begin
      seg_act   = bcd_para_seg({1'b0, snap_sel});
      ponto_act = 1'b1;
    end else if ((idx != '0) && !resto_nz) begin
      seg_act = 7'b0000000;
    end
    // The first cycle of each slot keeps every digit off so the previous
    // digit's segments cannot ghost onto the newly enabled one.
    anodo_act = (cnt == '0) ? '0 : (ANODO_UM << idx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      idx           <= '0;
      snap_valor    <= '0;
      snap_sel      <= '0;
      bus.segmentos <= SEG_OFF;
      bus.ponto     <= INV;
      bus.anodo     <= ANODO_OFF;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (bus.carregar) begin
        snap_valor <= bus.valor;
        snap_sel   <= bus.seletor;
      end

      // Outputs come from the pre-edge state, so a snapshot taken on this
      // edge first shows on the following cycle.
      if (bus.limpar) begin
        bus.segmentos <= SEG_OFF;
        bus.ponto     <= INV;
        bus.anodo     <= ANODO_OFF;
      end else begin
        bus.segmentos <= seg_act ^ SEG_OFF;
        bus.ponto     <= ponto_act ^ INV;
        bus.anodo     <= anodo_act ^ ANODO_OFF;
      end
    end
  end
endmodule

// File: tb/tb_decodificador_varredura.sv
// Bench for decodificador_varredura: an active-low and an active-high instance
// share identical stimulus; both are compared every cycle against a model that
// derives slot position from elapsed cycles since reset.
module tb_decodificador_varredura;
  localparam int N   = 5;
  localparam int DIV = 4;
  localparam int NS  = N + 1;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        limpar   = 1'b0;
  logic        carregar = 1'b0;
  logic [19:0] valor    = '0;
  logic [2:0]  seletor  = '0;

  decodificador_varredura_if #(.N_DIGITOS(N)) bus0 ();
  decodificador_varredura_if #(.N_DIGITOS(N)) bus1 ();

  assign bus0.limpar   = limpar;
  assign bus0.carregar = carregar;
  assign bus0.valor    = valor;
  assign bus0.seletor  = seletor;
  assign bus1.limpar   = limpar;
  assign bus1.carregar = carregar;
  assign bus1.valor    = valor;
  assign bus1.seletor  = seletor;

  decodificador_varredura #(.N_DIGITOS(N), .DIV_VARREDURA(DIV), .ATIVO_BAIXO(1)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );
  decodificador_varredura #(.N_DIGITOS(N), .DIV_VARREDURA(DIV), .ATIVO_BAIXO(0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );

  int testes = 0;
  int falhas = 0;

  // reference model state
  int         m_ticks = 0;
  int         m_valor = 0;
  logic [2:0] m_sel   = '0;
  logic [6:0] tab [0:9] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                            7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                            7'b1111111, 7'b1101111};

  // Expected active-high {segmentos, ponto, anodo} for the coming edge.
  function automatic logic [13:0] modelo_saida();
    int slot, c, d;
    logic [6:0] s;
    logic       p;
    logic [5:0] a;
    if (reset || limpar) return 14'h0;
    slot = (m_ticks / DIV) % NS;
    c    = m_ticks % DIV;
    a    = (c == 0) ? 6'h0 : 6'(1 << slot);
    if (slot == N) begin
      s = tab[int'(m_sel)];
      p = 1'b1;
    end else begin
      d = (m_valor >> (4 * slot)) & 15;
      s = (d > 9) ? 7'b1000000 : tab[d];
      if (slot > 0 && (m_valor >> (4 * slot)) == 0) s = 7'b0000000;
      p = 1'b0;
    end
    return {s, p, a};
  endfunction

  // scoreboard
  task automatic checar(input string nome, input logic [13:0] obtido, input logic [13:0] esperado);
    testes++;
    if (obtido !== esperado) begin
      falhas++;
      $display("FAIL %s: got %b expected %b", nome, obtido, esperado);
    end
  endtask

  function automatic logic [13:0] saida0();
    return {bus0.segmentos, bus0.ponto, bus0.anodo};
  endfunction

  function automatic logic [13:0] saida1();
    return {bus1.segmentos, bus1.ponto, bus1.anodo};
  endfunction

  // driver: one clock, model update, per-cycle comparison of both instances
  task automatic passo();
    logic [13:0] esp;
    esp = modelo_saida();
    @(posedge clk);
    if (reset) begin
      m_ticks = 0;
      m_valor = 0;
      m_sel   = '0;
    end else begin
      m_ticks++;
      if (carregar) begin
        m_valor = int'(valor);
        m_sel   = seletor;
      end
    end
    #1;
    checar("modelo_ativo_baixo", saida0(), ~esp);
    checar("modelo_ativo_alto", saida1(), esp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    passo();
    reset = 1'b0;
  endtask

  task automatic carregar_valor(input logic [19:0] v, input logic [2:0] s);
    valor    = v;
    seletor  = s;
    carregar = 1'b1;
    passo();
    carregar = 1'b0;
  endtask

  typedef struct {
    logic [19:0] valor;
    logic [2:0]  sel;
    int          slot;
    logic [6:0]  seg;
    logic        ponto;
    logic [5:0]  anodo;
  } vetor_t;

  vetor_t tabela [13];

  initial begin
    int inativos;
    // active-low expectations; the active-high instance must show the inverse
    tabela[0]  = '{20'h01234, 3'd3, 0, 7'b0011001, 1'b1, 6'b111110};
    tabela[1]  = '{20'h01234, 3'd3, 4, 7'b1111111, 1'b1, 6'b101111};
    tabela[2]  = '{20'h01234, 3'd3, 5, 7'b0110000, 1'b0, 6'b011111};
    tabela[3]  = '{20'h01234, 3'd3, 1, 7'b0110000, 1'b1, 6'b111101};
    tabela[4]  = '{20'h00000, 3'd0, 0, 7'b1000000, 1'b1, 6'b111110};
    tabela[5]  = '{20'h00000, 3'd0, 2, 7'b1111111, 1'b1, 6'b111011};
    tabela[6]  = '{20'h0A000, 3'd2, 3, 7'b0111111, 1'b1, 6'b110111};
    tabela[7]  = '{20'h0A000, 3'd2, 1, 7'b1000000, 1'b1, 6'b111101};
    tabela[8]  = '{20'h0A000, 3'd2, 4, 7'b1111111, 1'b1, 6'b101111};
    tabela[9]  = '{20'h98765, 3'd7, 4, 7'b0010000, 1'b1, 6'b101111};
    tabela[10] = '{20'h98765, 3'd7, 5, 7'b1111000, 1'b0, 6'b011111};
    tabela[11] = '{20'hF0000, 3'd1, 2, 7'b1000000, 1'b1, 6'b111011};
    tabela[12] = '{20'h00001, 3'd0, 0, 7'b1111001, 1'b1, 6'b111110};

    do_reset();
    checar("reset_ativo_baixo", saida0(), 14'h3FFF);
    checar("reset_ativo_alto", saida1(), 14'h0000);

    // table-driven vectors: load at cnt=0, then land on cnt=1 of the target slot
    for (int i = 0; i < 13; i++) begin
      do_reset();
      carregar_valor(tabela[i].valor, tabela[i].sel);
      repeat (tabela[i].slot * DIV + 1) passo();
      checar($sformatf("tabela_%0d_ab", i), saida0(),
             {tabela[i].seg, tabela[i].ponto, tabela[i].anodo});
      checar($sformatf("tabela_%0d_aa", i), saida1(),
             ~{tabela[i].seg, tabela[i].ponto, tabela[i].anodo});
    end

    // timing: one blank-anodo cycle per slot, 24-cycle scan period, wrap 5->0
    do_reset();
    carregar_valor(20'h01234, 3'd3);
    inativos = 0;
    for (int i = 0; i < NS * DIV; i++) begin
      passo();
      if (bus0.anodo == 6'h3F) inativos++;
    end
    checar("inativos_por_varredura", 14'(inativos), 14'(NS));
    passo();
    checar("volta_slot0", saida0(), {7'b0011001, 1'b1, 6'b111110});

    // inputs change without carregar: display keeps the snapshot
    valor   = 20'h99999;
    seletor = 3'd7;
    repeat (NS * DIV) passo();
    checar("sem_carregar", saida0(), {7'b0011001, 1'b1, 6'b111110});

    // carregar on the slot-change edge (slot 0 -> slot 1)
    passo();
    valor    = 20'h01274;
    carregar = 1'b1;
    passo();
    carregar = 1'b0;
    checar("troca_antes", saida0(), {7'b0011001, 1'b1, 6'b111110});
    passo();
    checar("troca_depois", saida0(), {7'b1111000, 1'b1, 6'b111111});

    // limpar for 10 cycles, scanning continues underneath
    limpar = 1'b1;
    for (int i = 0; i < 10; i++) begin
      passo();
      checar("limpar", saida0(), 14'h3FFF);
    end
    limpar = 1'b0;
    passo();
    checar("limpar_solto", saida0(), {7'b1111001, 1'b1, 6'b110111});

    // reset in the middle of slot 3, with carregar high
    for (int k = 0; k < 200 && (m_ticks % (NS * DIV)) != 13; k++) passo();
    reset    = 1'b1;
    carregar = 1'b1;
    valor    = 20'h55555;
    passo();
    checar("reset_meio_ab", saida0(), 14'h3FFF);
    checar("reset_meio_aa", saida1(), 14'h0000);
    reset    = 1'b0;
    carregar = 1'b0;
    passo();
    checar("reinicio_cnt0", saida0(), {7'b1000000, 1'b1, 6'b111111});
    passo();
    checar("reinicio_slot0", saida0(), {7'b1000000, 1'b1, 6'b111110});

    // randomized stimulus against the model
    for (int i = 0; i < 600; i++) begin
      carregar = ($urandom_range(0, 7) == 0);
      limpar   = ($urandom_range(0, 15) == 0);
      reset    = ($urandom_range(0, 99) == 0);
      valor    = 20'($urandom);
      if ($urandom_range(0, 1) == 0) valor = valor & 20'h000FF;
      seletor  = 3'($urandom_range(0, 7));
      passo();
    end
    reset    = 1'b0;
    carregar = 1'b0;
    limpar   = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end
endmodule
